// File: rtl/mul_unit_pkg.sv
// Shared definitions for the iterative multiplier: ALU opcodes common with decode/ALU,
// and the multiplier FSM state encoding.
package mul_unit_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_ORR  = 3'b011;
    localparam logic [2:0] ALU_UMUL = 3'b101;
    localparam logic [2:0] ALU_SMUL = 3'b110;
    localparam logic [2:0] ALU_MUL  = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } mul_state_e;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == ALU_MUL) || (op == ALU_SMUL) || (op == ALU_UMUL);
    endfunction

endpackage

// File: rtl/mul_unit_twos_neg.sv
// Conditional two's-complement negate; used for operand magnitudes and the product fix-up.
module mul_unit_twos_neg #(
    parameter int unsigned W = 32
) (
    input  logic         neg_i,
    input  logic [W-1:0] a_i,
    output logic [W-1:0] y_o
);

    always_comb begin
        y_o = neg_i ? -a_i : a_i;
    end

endmodule

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier with start/busy/done handshake.
// Handles MUL (low half), UMUL and SMUL (full 2*WIDTH product, sign fixed up after the loop).
module mul_unit
    import mul_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       Flags
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_e           state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [1:0]           flags_q, flags_d;

    logic                 in_smul;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH:0]       sum;

    assign in_smul = (ALUControl == ALU_SMUL);

    mul_unit_twos_neg #(.W(WIDTH)) u_abs_a (
        .neg_i (in_smul & SrcA[WIDTH-1]),
        .a_i   (SrcA),
        .y_o   (abs_a)
    );

    mul_unit_twos_neg #(.W(WIDTH)) u_abs_b (
        .neg_i (in_smul & SrcB[WIDTH-1]),
        .a_i   (SrcB),
        .y_o   (abs_b)
    );

    mul_unit_twos_neg #(.W(2 * WIDTH)) u_fix (
        .neg_i (neg_q),
        .a_i   (acc_q),
        .y_o   (product)
    );

    // Upper-half add keeps its carry; it becomes the accumulator MSB after the shift.
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        flags_d  = flags_q;

        unique case (state_q)
            StIdle: begin
                if (start && is_mul_op(ALUControl)) begin
                    state_d  = StRun;
                    op_d     = ALUControl;
                    neg_d    = in_smul & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
                    mcand_d  = abs_a;
                    mplier_d = abs_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            StRun: begin
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                lo_d = product[WIDTH-1:0];
                if (op_q == ALU_MUL) begin
                    hi_d    = '0;
                    flags_d = {product[WIDTH-1], product[WIDTH-1:0] == '0};
                end else begin
                    hi_d    = product[2*WIDTH-1:WIDTH];
                    flags_d = {product[2*WIDTH-1], product == '0};
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            flags_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            flags_q  <= flags_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign ResultLo = lo_q;
    assign ResultHi = hi_q;
    assign Flags    = flags_q;

endmodule
